// File: rtl/zw_accum.sv
// zw_accum: frame averager for a 16-lane signed Q13 product matrix.
// It accumulates 2^N_LOG2 accepted beats per frame and emits the
// per-lane mean, floored, through a valid/ready output stage.
// Ports:
//   clk_acc   - clock, all state updates on the rising edge
//   rstn_acc  - synchronous active-low reset
//   start     - begin a new frame (honoured only in IDLE)
//   in_valid  - zw_in carries a sample
//   zw_in     - 16 x 26-bit signed lanes, lane k at [26k+25:26k]
//   in_ready  - a sample is accepted this cycle (state ACC)
//   out_valid - mean_out holds a completed frame mean (state DONE)
//   out_ready - the consumer takes mean_out
//   mean_out  - 16 x 26-bit signed lanes, same packing as zw_in
//   busy      - state is ACC or DONE
module zw_accum #(
  parameter int unsigned N_LOG2 = 8
) (
  input  logic         clk_acc,
  input  logic         rstn_acc,
  input  logic         start,
  input  logic         in_valid,
  input  logic [415:0] zw_in,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [415:0] mean_out,
  output logic         busy
);

  localparam int unsigned LANES = 16;
  localparam int unsigned LW    = 26;
  localparam int unsigned AW    = LW + N_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_LOG2-1:0]   cnt_q;
  logic signed [AW-1:0] acc_q [LANES];
  logic signed [AW-1:0] sum_c [LANES];
  logic                beat_c;
  logic                last_c;

  // Beat acceptance and end-of-frame detection
  assign beat_c = (state_q == ACC) && in_valid;
  assign last_c = (cnt_q == '1);

  // Per-lane running sum including the current beat, sign-extended
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_c[k] = acc_q[k] + AW'($signed(zw_in[k*LW +: LW]));
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (beat_c && last_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, flags, accumulators, counter and result registers
  always_ff @(posedge clk_acc) begin
    if (!rstn_acc) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt_q     <= '0;
      mean_out  <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      // Flags are registered copies of the next-state decode
      in_ready  <= (state_d == ACC);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if ((state_q == IDLE) && start) begin
        cnt_q <= '0;
        for (int unsigned k = 0; k < LANES; k++) begin
          acc_q[k] <= '0;
        end
      end else if (beat_c) begin
        // Counter wraps to zero on the last beat of the frame
        cnt_q <= cnt_q + N_LOG2'(1);
        for (int unsigned k = 0; k < LANES; k++) begin
          acc_q[k] <= sum_c[k];
        end
        if (last_c) begin
          // Arithmetic shift floors; the mean always fits in 26 bits
          for (int unsigned k = 0; k < LANES; k++) begin
            mean_out[k*LW +: LW] <= LW'(sum_c[k] >>> N_LOG2);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zw_accum.sv
// Testbench for zw_accum with N_LOG2=2: directed frames checked against
// an arithmetic reference model every cycle plus literal expectations.
module tb_zw_accum;

  localparam int unsigned N_LOG2 = 2;
  localparam int          NBEAT  = 4;

  logic         clk_acc;
  logic         rstn_acc;
  logic         start;
  logic         in_valid;
  logic [415:0] zw_in;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [415:0] mean_out;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  zw_accum #(.N_LOG2(N_LOG2)) dut (
    .clk_acc  (clk_acc),
    .rstn_acc (rstn_acc),
    .start    (start),
    .in_valid (in_valid),
    .zw_in    (zw_in),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mean_out (mean_out),
    .busy     (busy)
  );

  initial clk_acc = 1'b0;
  always #5 clk_acc = ~clk_acc;

  // Reference model: 0 idle, 1 accumulating, 2 result held
  int          m_state = 0;
  int          m_cnt   = 0;
  longint      m_sum  [16];
  logic [25:0] m_mean [16];

  initial begin
    for (int k = 0; k < 16; k++) begin
      m_sum[k]  = 0;
      m_mean[k] = '0;
    end
  end

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / NBEAT;
    if ((s < 0) && ((s % NBEAT) != 0)) q = q - 1;
    return q;
  endfunction

  always @(posedge clk_acc) begin
    if (!rstn_acc) begin
      m_state = 0;
      m_cnt   = 0;
      for (int k = 0; k < 16; k++) begin
        m_sum[k]  = 0;
        m_mean[k] = '0;
      end
    end else begin
      case (m_state)
        0: if (start) begin
             m_state = 1;
             m_cnt   = 0;
             for (int k = 0; k < 16; k++) m_sum[k] = 0;
           end
        1: if (in_valid) begin
             for (int k = 0; k < 16; k++)
               m_sum[k] = m_sum[k] + longint'($signed(zw_in[26*k +: 26]));
             m_cnt = m_cnt + 1;
             if (m_cnt == NBEAT) begin
               for (int k = 0; k < 16; k++)
                 m_mean[k] = 26'(floor_div(m_sum[k]));
               m_state = 2;
             end
           end
        default: if (out_ready) m_state = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [415:0] act, input logic [415:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_acc) begin
    logic [415:0] exp_mean;
    for (int k = 0; k < 16; k++) exp_mean[26*k +: 26] = m_mean[k];
    chk("in_ready",  {415'd0, in_ready},  {415'd0, (m_state == 1)});
    chk("out_valid", {415'd0, out_valid}, {415'd0, (m_state == 2)});
    chk("busy",      {415'd0, busy},      {415'd0, (m_state != 0)});
    chk("mean_out",  mean_out, exp_mean);
  end

  logic [415:0] beats [NBEAT];

  task automatic tick();
    @(posedge clk_acc);
    #1;
  endtask

  // Run one frame from the stored beats; optionally insert idle gaps
  task automatic run_frame(input bit gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NBEAT; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        zw_in    = '1;
        tick();
      end
      in_valid = 1'b1;
      zw_in    = beats[i];
      tick();
    end
    in_valid = 1'b0;
    zw_in    = '0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_ready", {414'd0, out_valid, busy}, 416'd0);
  endtask

  task automatic fill_all(input logic [25:0] v);
    for (int i = 0; i < NBEAT; i++) beats[i] = {16{v}};
  endtask

  task automatic one_lane(input int lane, input logic [25:0] a, input logic [25:0] b,
                          input logic [25:0] c, input logic [25:0] d);
    logic [25:0] v [NBEAT];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < NBEAT; i++) begin
      beats[i] = '0;
      beats[i][26*lane +: 26] = v[i];
    end
  endtask

  logic [415:0] held;
  logic [415:0] lane5_m1;

  initial begin
    rstn_acc  = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    zw_in     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_state", {mean_out[412:0], in_ready, out_valid, busy}, 416'd0);
    rstn_acc = 1'b1;
    tick();

    // 1.0 in every lane
    fill_all(26'h0002000);
    run_frame(1'b0);
    chk("latency_valid", {415'd0, out_valid}, 416'd1);
    chk("mean_one", mean_out, {16{26'h0002000}});
    release_out();

    // Lane 0 = 1,2,3,5 -> 11>>>2 = 2
    one_lane(0, 26'd1, 26'd2, 26'd3, 26'd5);
    run_frame(1'b0);
    chk("mean_lane0", mean_out, 416'd2);
    release_out();

    lane5_m1 = '0;
    lane5_m1[26*5 +: 26] = 26'h3FFFFFF;

    // Lane 5 = -1 on every beat
    one_lane(5, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF);
    run_frame(1'b0);
    chk("mean_lane5_neg", mean_out, lane5_m1);
    release_out();

    // Lane 5 = -1,0,0,0 -> floor(-1/4) = -1
    one_lane(5, 26'h3FFFFFF, 26'd0, 26'd0, 26'd0);
    run_frame(1'b0);
    chk("mean_lane5_floor", mean_out, lane5_m1);
    release_out();

    // Positive and negative extremes
    fill_all(26'h1FFFFFF);
    run_frame(1'b0);
    chk("mean_max", mean_out, {16{26'h1FFFFFF}});
    release_out();
    fill_all(26'h2000000);
    run_frame(1'b0);
    chk("mean_min", mean_out, {16{26'h2000000}});

    // Hold: output stable, no input accepted, start ignored
    held = mean_out;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mean", mean_out, held);
      chk("hold_flags", {413'd0, out_valid, in_ready, busy}, {413'd0, 3'b101});
    end
    start = 1'b0;
    release_out();

    // Gapped input gives the same result as back-to-back
    one_lane(0, 26'd1, 26'd2, 26'd3, 26'd5);
    run_frame(1'b1);
    chk("mean_gapped", mean_out, 416'd2);
    release_out();

    // Reset after two beats abandons the frame
    fill_all(26'h1FFFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    zw_in = beats[0];
    tick();
    tick();
    in_valid = 1'b0;
    rstn_acc = 1'b0;
    start = 1'b1;
    tick();
    rstn_acc = 1'b1;
    start = 1'b0;
    chk("abandon_reset", {mean_out[412:0], in_ready, out_valid, busy}, 416'd0);
    fill_all(26'h0004000);
    run_frame(1'b0);
    chk("mean_after_abandon", mean_out, {16{26'h0004000}});

    // Reset while DONE drops the result
    rstn_acc = 1'b0;
    tick();
    rstn_acc = 1'b1;
    chk("reset_in_done", {mean_out[412:0], in_ready, out_valid, busy}, 416'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/zw_accum.md
ZW_ACCUM -- requirements
Module: zw_accum

Interface
REQ-001 Parameter: N_LOG2, default 8, log2 of the number of samples averaged per frame (legal range 1..16).
REQ-002 clk_acc  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rstn_acc  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin a new averaging frame.
REQ-005 in_valid  input  1  zw_in carries a valid product-matrix sample this cycle.
REQ-006 zw_in  input  416  16 signed Q13 lanes of 26 bits each; lane k = 4*(row-1)+(col-1) occupies bits [26k+25:26k].
REQ-007 in_ready  output  1  the block accepts a sample this cycle.
REQ-008 out_valid  output  1  mean_out holds a completed frame mean.
REQ-009 out_ready  input  1  the consumer takes mean_out this cycle.
REQ-010 mean_out  output  416  16 signed Q13 lanes of 26 bits each, with the same lane packing as zw_in.
REQ-011 busy  output  1  the block is in the ACC or DONE state.

Function
REQ-012 States SHALL be IDLE, ACC and DONE, encoded in a registered state variable.
REQ-013 IDLE -> ACC SHALL occur when start=1; on that same edge all 16 accumulators and the sample counter SHALL be cleared.
REQ-014 start SHALL be ignored in ACC and in DONE.
REQ-015 in_ready SHALL be 1 exactly when state=ACC; a beat is accepted only when in_valid=1 and in_ready=1.
REQ-016 Each accepted beat SHALL add every lane, sign-extended to 26+N_LOG2 bits, into its own accumulator; this width guarantees no overflow.
REQ-017 The counter SHALL be N_LOG2 bits wide and increment by one per accepted beat.
REQ-018 On the beat accepted with counter = 2^N_LOG2-1:
  - the next state SHALL be DONE;
  - each mean_out lane SHALL be loaded with (acc+lane) >>> N_LOG2, an arithmetic shift rounding toward minus infinity;
  - the result always fits in 26 bits, so there is no saturation.
REQ-019 Latency: out_valid SHALL rise on the cycle after the last accepted beat.
REQ-020 out_valid SHALL be 1 exactly when state=DONE; mean_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 DONE -> IDLE SHALL occur on the edge where out_ready=1.
REQ-022 mean_out SHALL hold its last value in IDLE and in ACC; it is only reloaded per REQ-018.
REQ-023 Cycles in ACC with in_valid=0 SHALL leave the accumulators and the counter unchanged.
REQ-024 busy SHALL be 1 exactly when state is ACC or DONE.
REQ-025 The block SHALL accept back-to-back beats, one per cycle, with no bubbles.

Reset
REQ-026 When rstn_acc=0 at a clock edge, the following SHALL apply on that edge:
  - state = IDLE;
  - accumulators, counter and mean_out = 0;
  - in_ready, out_valid and busy = 0.
REQ-027 Reset asserted mid-frame or in DONE SHALL abandon the frame with no partial output; out_valid stays 0 until a full new frame completes.
REQ-028 Reset SHALL take priority over start, in_valid and out_ready on the same edge.

Verification (N_LOG2=2)
REQ-029 Reset then start, then 4 beats with all lanes = 0x0002000 (1.0) -> out_valid one cycle after the 4th beat, all lanes 0x0002000.
REQ-030 Lane 0 sequence 1, 2, 3, 5 (raw LSBs), all other lanes 0 -> lane 0 = 2 (11>>>2), other lanes 0.
REQ-031 Lane 5 = -1 (0x3FFFFFF) on all 4 beats -> lane 5 = 0x3FFFFFF; lane 5 = -1, 0, 0, 0 -> lane 5 = 0x3FFFFFF (floor).
REQ-032 Extremes: all lanes 0x1FFFFFF x4 -> 0x1FFFFFF; all lanes 0x2000000 x4 -> 0x2000000 (no overflow).
REQ-033 Handshake:
  - in_valid toggled 1,0,1,0,... -> result identical to back-to-back input;
  - out_ready held 0 for 5 cycles -> out_valid and mean_out stable, in_ready=0, start ignored;
  - out_ready=1 -> IDLE next cycle.
REQ-034 Reset after 2 of 4 beats, then start and 4 beats of 0x0004000 -> result 0x0004000, no contribution from the abandoned beats.
